// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and load (B)
// write-back paths, with a registered write stage and per-register pending-write counters.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_dest,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_dest,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                issue_ready,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy,
    output logic                writeBackEn,
    output logic [ADDR_W-1:0]   Dest_wb,
    output logic [DATA_W-1:0]   Result_WB,
    output logic                err_pc,
    output logic                err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a transfer happens when x_valid && x_ready; x_ready is combinational and
    // only the granted requester sees it; an unaccepted requester holds dest/data stable.
    logic                rr_a;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic                grant_a, grant_b;
    logic                xfer_a, xfer_b, xfer, xfer_wr;
    logic [ADDR_W-1:0]   xdest;
    logic [DATA_W-1:0]   xdata;
    logic                issue_sat, issue_ok;
    logic [NUM_REGS-1:0] inc_v, dec_v;

    function automatic logic writable(input logic [ADDR_W-1:0] d);
        return 32'(d) < NUM_REGS;
    endfunction

    always_comb begin
        grant_a = a_valid && (rr_a || !b_valid);
        grant_b = b_valid && (!rr_a || !a_valid);
    end

    assign a_ready = rst && grant_a;
    assign b_ready = rst && grant_b;
    assign xfer_a  = a_valid && a_ready;
    assign xfer_b  = b_valid && b_ready;
    assign xfer    = xfer_a || xfer_b;
    assign xdest   = xfer_a ? a_dest : b_dest;
    assign xdata   = xfer_a ? a_data : b_data;
    assign xfer_wr = xfer && writable(xdest);

    // Loop compare instead of indexing cnt[issue_dest], since the PC index has no counter.
    always_comb begin
        issue_sat = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_dest == ADDR_W'(i) && cnt[i] == CNT_MAX)
                issue_sat = 1'b1;
        end
        issue_ready = rst && !issue_sat;
        issue_ok    = issue_en && issue_ready && writable(issue_dest);
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i]  = cnt[i] != '0;
            inc_v[i] = issue_ok && issue_dest == ADDR_W'(i);
            dec_v[i] = xfer_wr && xdest == ADDR_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            writeBackEn   <= 1'b0;
            Dest_wb       <= '0;
            Result_WB     <= '0;
            rr_a          <= 1'b1;
            err_pc        <= 1'b0;
            err_underflow <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
        end else begin
            writeBackEn <= xfer_wr;
            if (xfer_wr) begin
                Dest_wb   <= xdest;
                Result_WB <= xdata;
            end
            if (xfer)
                rr_a <= xfer_b;
            if (xfer && !writable(xdest))
                err_pc <= 1'b1;
            // Issue and retire to the same register cancel out.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (flush)
                    cnt[i] <= '0;
                else if (inc_v[i] && !dec_v[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec_v[i] && !inc_v[i]) begin
                    if (cnt[i] == '0)
                        err_underflow <= 1'b1;
                    else
                        cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin order, write latency,
// scoreboard counters, PC/underflow errors, flush and reset behaviour.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [3:0]  a_dest, b_dest, issue_dest, Dest_wb;
    logic [31:0] a_data, b_data, Result_WB;
    logic        issue_en, issue_ready, flush;
    logic [14:0] busy;
    logic        writeBackEn, err_pc, err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
        .issue_en(issue_en), .issue_dest(issue_dest), .issue_ready(issue_ready),
        .flush(flush), .busy(busy),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
        .err_pc(err_pc), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] d);
        issue_en   = 1'b1;
        issue_dest = d;
        #1 check("issue_rdy", issue_ready, 1);
        @(negedge clk);
        issue_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0;
        a_valid = 1'b0; a_dest = '0; a_data = '0;
        b_valid = 1'b0; b_dest = '0; b_data = '0;
        issue_en = 1'b0; issue_dest = '0;

        // Reset, with requesters valid to show ready stays low
        repeat (2) @(negedge clk);
        a_valid = 1'b1; a_dest = 4'd3; b_valid = 1'b1; b_dest = 4'd2; issue_dest = 4'd1;
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_issue_rdy", issue_ready, 0);
        check("rst_wbe", writeBackEn, 0);
        check("rst_busy", busy, 0);
        check("rst_err_pc", err_pc, 0);
        check("rst_err_uf", err_underflow, 0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;

        issue(4'd3); issue(4'd8); issue(4'd1); issue(4'd1); issue(4'd2); issue(4'd2);

        // A only
        a_valid = 1'b1; a_dest = 4'd3; a_data = 32'hDEAD;
        #1 check("a_only_ready", a_ready, 1);
        check("a_only_b_ready", b_ready, 0);
        @(negedge clk);
        a_valid = 1'b0;
        check("a_only_wbe", writeBackEn, 1);
        check("a_only_dest", Dest_wb, 3);
        check("a_only_data", Result_WB, 32'hDEAD);
        @(negedge clk);
        check("a_only_wbe_off", writeBackEn, 0);
        check("a_only_hold", Dest_wb, 3);

        // B only; leaves the pointer favouring A
        b_valid = 1'b1; b_dest = 4'd8; b_data = 32'h88;
        #1 check("b_only_ready", b_ready, 1);
        check("b_only_a_ready", a_ready, 0);
        @(negedge clk);
        b_valid = 1'b0;
        check("b_only_dest", Dest_wb, 8);
        check("b_only_data", Result_WB, 32'h88);

        // Contention: A,B,A,B
        a_valid = 1'b1; a_dest = 4'd1; a_data = 32'hA1;
        b_valid = 1'b1; b_dest = 4'd2; b_data = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
            check("rr_b_ready", b_ready, (k % 2 == 1) ? 1 : 0);
            if (k > 0) begin
                check("rr_wbe", writeBackEn, 1);
                check("rr_dest", Dest_wb, (k % 2 == 1) ? 1 : 2);
            end
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("rr_last_wbe", writeBackEn, 1);
        check("rr_last_dest", Dest_wb, 2);
        check("rr_last_data", Result_WB, 32'hB2);
        @(negedge clk);
        check("rr_idle_wbe", writeBackEn, 0);
        check("rr_busy_clear", busy, 0);
        check("rr_no_uf", err_underflow, 0);

        // Scoreboard saturation on reg 5
        issue(4'd5); issue(4'd5); issue(4'd5);
        issue_dest = 4'd5;
        #1 check("sat_ready", issue_ready, 0);
        check("sat_busy5", busy[5], 1);
        issue_en = 1'b1;
        @(negedge clk);
        issue_en = 1'b0;
        b_valid = 1'b1; b_dest = 4'd5; b_data = 32'h55;
        #1 check("sb_b_ready", b_ready, 1);
        @(negedge clk);
        b_valid = 1'b0;
        #1 check("sb_ready_after_dec", issue_ready, 1);
        check("sb_busy5", busy[5], 1);
        issue(4'd5);
        #1 check("sb_cnt_was_2", issue_ready, 0);
        check("sb_no_uf", err_underflow, 0);

        // Write to PC index
        a_valid = 1'b1; a_dest = 4'd15; a_data = 32'hFF;
        #1 check("pc_ready", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        check("pc_wbe", writeBackEn, 0);
        check("pc_err", err_pc, 1);
        check("pc_dest_hold", Dest_wb, 5);
        check("pc_no_uf", err_underflow, 0);

        // Underflow on idle reg 7
        b_valid = 1'b1; b_dest = 4'd7; b_data = 32'h77;
        @(negedge clk);
        b_valid = 1'b0;
        check("uf_err", err_underflow, 1);
        check("uf_wbe", writeBackEn, 1);
        check("uf_dest", Dest_wb, 7);
        check("uf_busy", busy, 15'h0020);

        // Issue and write reg 4 together
        issue(4'd4);
        issue_en = 1'b1; issue_dest = 4'd4;
        a_valid = 1'b1; a_dest = 4'd4; a_data = 32'h44;
        #1 check("same_a_ready", a_ready, 1);
        check("same_issue_rdy", issue_ready, 1);
        @(negedge clk);
        issue_en = 1'b0; a_valid = 1'b0;
        check("same_wbe", writeBackEn, 1);
        check("same_dest", Dest_wb, 4);
        check("same_busy4", busy[4], 1);
        issue(4'd4);
        issue_dest = 4'd4;
        #1 check("same_cnt_was_1", issue_ready, 1);
        issue(4'd4);
        #1 check("same_cnt_sat", issue_ready, 0);

        // flush with a simultaneous issue
        issue(4'd6);
        #1 check("pre_flush_busy", busy, 15'h0070);
        flush = 1'b1; issue_en = 1'b1; issue_dest = 4'd6;
        @(negedge clk);
        flush = 1'b0; issue_en = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_wbe", writeBackEn, 0);
        check("flush_dest_hold", Dest_wb, 4);
        issue_dest = 4'd15;
        #1 check("pc_issue_rdy", issue_ready, 1);

        // Reset while A is valid
        rst = 1'b0; a_valid = 1'b1; a_dest = 4'd9; a_data = 32'h99;
        #1 check("rst2_a_ready", a_ready, 0);
        @(negedge clk);
        check("rst2_wbe", writeBackEn, 0);
        check("rst2_dest", Dest_wb, 0);
        check("rst2_data", Result_WB, 0);
        check("rst2_err_pc", err_pc, 0);
        check("rst2_err_uf", err_underflow, 0);
        check("rst2_busy", busy, 0);
        rst = 1'b1; b_valid = 1'b1; b_dest = 4'd10; b_data = 32'hAA;
        #1 check("rst2_rr_a", a_ready, 1);
        check("rst2_rr_b", b_ready, 0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        check("rst2_wr_dest", Dest_wb, 9);
        check("rst2_wr_data", Result_WB, 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
